// File: rtl/matrix_stream_pkg.sv
// rtl/matrix_stream_pkg.sv - shared state encoding, frame geometry and golden value
// for the matrix operand source and its output checker.
package matrix_stream_pkg;

   typedef enum logic [1:0] {
      ST_WAIT = 2'd0,
      ST_SEND = 2'd1,
      ST_GAP  = 2'd2,
      ST_DONE = 2'd3
   } stream_state_t;

   localparam int DEFAULT_MATRIX_DIM = 6;

   // One frame carries matrix A followed by matrix B.
   function automatic int words_per_frame(input int dim);
      return 2 * dim * dim;
   endfunction

   localparam int          WORDS_PER_FRAME = words_per_frame(DEFAULT_MATRIX_DIM);
   localparam logic [31:0] GOLDEN_VALUE    = 32'd42;

endpackage

// File: rtl/matrix_source_rt_if.sv
// rtl/matrix_source_rt_if.sv - operand stream from the source into the multiplier
// input port.
interface matrix_source_rt_if;

   logic        input_r_TVALID_0;
   logic        input_r_TLAST_0;
   logic [31:0] input_r_TDATA_0;
   logic        input_r_TREADY_0;

   modport master (
      output input_r_TVALID_0,
      output input_r_TLAST_0,
      output input_r_TDATA_0,
      input  input_r_TREADY_0
   );

   modport slave (
      input  input_r_TVALID_0,
      input  input_r_TLAST_0,
      input  input_r_TDATA_0,
      output input_r_TREADY_0
   );

endinterface

// File: rtl/start_delay_timer.sv
// rtl/start_delay_timer.sv - 20-bit post-reset delay; expired is high on the cycle
// whose edge should leave the wait state.
module start_delay_timer #(
   parameter logic [19:0] DELAY = 20'd20000
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic expired
);

   // A zero delay behaves like a one-cycle delay: leave on the first edge.
   localparam logic [19:0] LAST_COUNT = (DELAY == 20'd0) ? 20'd0 : DELAY - 20'd1;

   logic [19:0] count;

   assign expired = enable && (count == LAST_COUNT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (enable && !expired) begin
         count <= count + 20'd1;
      end
   end

endmodule

// File: rtl/matrix_source_rt.sv
// rtl/matrix_source_rt.sv - self-timed operand source: after a start delay streams
// A then B as one TLAST-terminated frame per multiplication.
module matrix_source_rt
   import matrix_stream_pkg::*;
#(
   parameter logic [19:0] Start_Delay_Value = 20'd20000,
   parameter int          MATRIX_DIM        = DEFAULT_MATRIX_DIM,
   parameter logic [31:0] FILL_A            = 32'd1,
   parameter logic [31:0] FILL_B            = 32'd7,
   parameter logic [3:0]  NUM_FRAMES        = 4'd1,
   parameter logic [7:0]  GAP_CYCLES        = 8'd0
) (
   input  logic                      clk,
   input  logic                      reset,
   matrix_source_rt_if.master        input_r,
   output logic [3:0]                Frames_Sent,
   output logic                      Done
);

   localparam int WORDS   = words_per_frame(MATRIX_DIM);
   localparam int A_WORDS = MATRIX_DIM * MATRIX_DIM;
   localparam int IDX_W   = $clog2(WORDS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

   stream_state_t    state, state_n;
   logic [IDX_W-1:0] idx, idx_n;
   logic [7:0]       gap_cnt, gap_cnt_n;
   logic             tvalid, tvalid_n;
   logic             tlast, tlast_n;
   logic [31:0]      tdata, tdata_n;
   logic [3:0]       frames, frames_n;
   logic             done, done_n;
   logic             delay_expired;
   logic             xfer;
   logic             last_frame;

   function automatic logic [31:0] word_data(input logic [IDX_W-1:0] i);
      return (int'(i) < A_WORDS) ? FILL_A : FILL_B;
   endfunction

   start_delay_timer #(
      .DELAY (Start_Delay_Value)
   ) u_start_delay_timer (
      .clk     (clk),
      .reset   (reset),
      .enable  (state == ST_WAIT),
      .expired (delay_expired)
   );

   assign xfer       = tvalid && input_r.input_r_TREADY_0;
   assign last_frame = (NUM_FRAMES != 4'd0) &&
                       (({1'b0, frames} + 5'd1) == {1'b0, NUM_FRAMES});

   always_comb begin
      state_n   = state;
      idx_n     = idx;
      gap_cnt_n = gap_cnt;
      tvalid_n  = tvalid;
      tlast_n   = tlast;
      tdata_n   = tdata;
      frames_n  = frames;
      done_n    = done;
      case (state)
         ST_WAIT: begin
            if (delay_expired) begin
               state_n  = ST_SEND;
               idx_n    = '0;
               tvalid_n = 1'b1;
               tdata_n  = word_data('0);
               tlast_n  = (LAST_IDX == '0);
            end
         end
         ST_SEND: begin
            if (xfer) begin
               if (idx == LAST_IDX) begin
                  frames_n = (frames == 4'hF) ? frames : frames + 4'd1;
                  idx_n    = '0;
                  if (last_frame) begin
                     state_n  = ST_DONE;
                     tvalid_n = 1'b0;
                     tlast_n  = 1'b0;
                     done_n   = 1'b1;
                  end else if (GAP_CYCLES == 8'd0) begin
                     tdata_n = word_data('0);
                     tlast_n = (LAST_IDX == '0);
                  end else begin
                     state_n   = ST_GAP;
                     gap_cnt_n = '0;
                     tvalid_n  = 1'b0;
                     tlast_n   = 1'b0;
                  end
               end else begin
                  idx_n   = idx + 1'b1;
                  tdata_n = word_data(idx + 1'b1);
                  tlast_n = ((idx + 1'b1) == LAST_IDX);
               end
            end
         end
         ST_GAP: begin
            // The edge that ends the last idle cycle presents word 0.
            if (gap_cnt == 8'(GAP_CYCLES - 8'd1)) begin
               state_n  = ST_SEND;
               tvalid_n = 1'b1;
               tdata_n  = word_data('0);
               tlast_n  = (LAST_IDX == '0);
            end else begin
               gap_cnt_n = gap_cnt + 8'd1;
            end
         end
         default: begin
            tvalid_n = 1'b0;
            tlast_n  = 1'b0;
            done_n   = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= ST_WAIT;
         idx     <= '0;
         gap_cnt <= '0;
         tvalid  <= 1'b0;
         tlast   <= 1'b0;
         tdata   <= '0;
         frames  <= '0;
         done    <= 1'b0;
      end else begin
         state   <= state_n;
         idx     <= idx_n;
         gap_cnt <= gap_cnt_n;
         tvalid  <= tvalid_n;
         tlast   <= tlast_n;
         tdata   <= tdata_n;
         frames  <= frames_n;
         done    <= done_n;
      end
   end

   assign input_r.input_r_TVALID_0 = tvalid;
   assign input_r.input_r_TLAST_0  = tlast;
   assign input_r.input_r_TDATA_0  = tdata;
   assign Frames_Sent              = frames;
   assign Done                     = done;

endmodule
